// File: rtl/adc_reader_if.sv
// Bus interface for adc_reader: the ADC request/ready/data handshake, burst
// control and status, and the read port of the capture buffer.
// The master modport is taken by adc_reader. The slave modport is the
// environment, which is the ADC plus whatever drains the buffer.
interface adc_reader_if #(
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          start;
  logic          req;
  logic          rdy;
  logic [7:0]    dat;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;

  modport master (
    input  start, rdy, dat, rd_en,
    output req, busy, done, count, rd_data, empty, full
  );

  modport slave (
    output start, rdy, dat, rd_en,
    input  req, busy, done, count, rd_data, empty, full
  );
endinterface

// File: rtl/adc_reader.sv
// adc_reader: captures a burst of ADC samples into a circular FIFO.
// A start pulse arms the reader. Each sample is requested with one rising
// edge on req. The ADC's rdy is synchronised into the clk domain. The burst
// ends on an 8'hFF terminator, when DEPTH samples have been taken, or when
// the buffer fills.
// Optional feature: define ADC_READER_TIMEOUT_EN to bound each wait for rdy
// to TIMEOUT cycles. This also adds the timeout_err output.
module adc_reader #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  adc_reader_if.master io_bus
`ifdef ADC_READER_TIMEOUT_EN
  ,
  output logic         timeout_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Reject configurations the pointer arithmetic cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("adc_reader: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("adc_reader: TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, ARM, WAIT, CAPTURE, DONE} state_t;

  state_t        r_state;
  logic          r_req;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_count;
  logic          r_dwell;     // set once WAIT has lasted one full cycle
  logic          r_rdy_m;
  logic          r_rdy_s;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [7:0]    r_rd_data;
  logic [7:0]    r_mem [DEPTH];

`ifdef ADC_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout_err;
`endif

  logic          w_empty;
  logic          w_full;
  logic          w_capture;
  logic          w_pop;
  logic          w_clear;
  logic [PW-1:0] w_occ;
  logic          w_will_full;
  logic [CW-1:0] w_count_inc;
  logic          w_last;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_capture   = (r_state == CAPTURE);
  assign w_pop       = io_bus.rd_en && !w_empty;
  assign w_clear     = (r_state == IDLE) && io_bus.start;
  assign w_occ       = r_wr_ptr - r_rd_ptr;
  // The buffer fills on this write unless a pop in the same cycle frees a slot.
  assign w_will_full = (w_occ == PW'(DEPTH - 1)) && !w_pop;
  assign w_count_inc = (r_count == DEPTH_C) ? r_count : r_count + 1'b1;
  assign w_last      = (io_bus.dat == 8'hFF) || (w_count_inc == DEPTH_C) || w_will_full;

  // Two-flop synchroniser for the asynchronous rdy. Only r_rdy_s is used below.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every flop
    // samples the values from before this edge and evaluation order does not matter.
    if (!rst) begin
      r_rdy_m <= 1'b0;
      r_rdy_s <= 1'b0;
    end else begin
      r_rdy_m <= io_bus.rdy;
      r_rdy_s <= r_rdy_m;
    end
  end

  // Burst control FSM. req/busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_dwell <= 1'b0;
`ifdef ADC_READER_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_state <= ARM;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_count <= '0;
`ifdef ADC_READER_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
          end
        end
        ARM: begin
          r_state <= WAIT;
          r_dwell <= 1'b0;
`ifdef ADC_READER_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        WAIT: begin
          r_dwell <= 1'b1;
`ifdef ADC_READER_TIMEOUT_EN
          r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
          // The two-cycle minimum lets rdy_s from the previous sample drain first.
          if (r_dwell && r_rdy_s) begin
            r_state <= CAPTURE;
            r_req   <= 1'b0;
          end
`ifdef ADC_READER_TIMEOUT_EN
          else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            r_state       <= DONE;
            r_req         <= 1'b0;
            r_done        <= 1'b1;
            r_timeout_err <= 1'b1;
          end
`endif
        end
        CAPTURE: begin
          r_count <= w_count_inc;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ARM;
            r_req   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and registered read data. start empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= 8'h00;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Sample storage. The write slot is always free when CAPTURE is reached.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Empty/full come from the pointers,
    // so stale contents are never observable, and a reset-free array can map onto RAM.
    if (w_capture) begin
      r_mem[r_wr_ptr[AW-1:0]] <= io_bus.dat;
    end
  end

  assign io_bus.req     = r_req;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.count   = r_count;
  assign io_bus.rd_data = r_rd_data;
  assign io_bus.empty   = w_empty;
  assign io_bus.full    = w_full;

`ifdef ADC_READER_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_adc_reader.sv
// Directed bench for adc_reader. It contains a simple ADC responder, a
// done/req-edge monitor and a linear sequence of directed steps.
// Define ADC_READER_TIMEOUT_EN to also exercise the timeout path (TIMEOUT=8).
`timescale 1ns/1ps
module tb_adc_reader;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 8;
  localparam int ADC_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_reader_if #(.DEPTH(DEPTH)) bus ();
`ifdef ADC_READER_TIMEOUT_EN
  logic timeout_err;
`endif

  adc_reader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
`ifdef ADC_READER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  int tests = 0;
  int fails = 0;

  // ADC responder: sees req, waits ADC_LAT cycles, then presents the next
  // value with rdy high. It holds dat and drops rdy once req falls.
  logic [7:0] adc_vals [$];
  int         adc_idx = 0;
  bit         adc_en  = 1'b0;
  int         adc_lat = 0;

  initial begin
    bus.rdy = 1'b0;
    bus.dat = 8'h00;
    forever begin
      @(negedge clk);
      if (!adc_en) begin
        bus.rdy = 1'b0;
        adc_lat = 0;
      end else if (bus.rdy && !bus.req) begin
        bus.rdy = 1'b0;
      end else if (!bus.rdy && bus.req) begin
        if (adc_lat == ADC_LAT) begin
          bus.dat = (adc_idx < adc_vals.size()) ? adc_vals[adc_idx] : 8'h00;
          adc_idx++;
          bus.rdy = 1'b1;
          adc_lat = 0;
        end else begin
          adc_lat++;
        end
      end
    end
  end

  // Monitor: counts done pulses and rising edges on req.
  int   done_cnt = 0;
  int   rise_cnt = 0;
  logic mon_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
      if (bus.req === 1'b1 && mon_prev === 1'b0) rise_cnt++;
      mon_prev = bus.req;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic load_adc(input logic [7:0] vals [$]);
    adc_vals = vals;
    adc_idx  = 0;
    adc_en   = 1'b1;
    done_cnt = 0;
    rise_cnt = 0;
  endtask

  // Returns at the negedge where done is high; an expired bound is a failure.
  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Returns at the negedge of the n-th falling req edge (a CAPTURE cycle).
  task automatic wait_req_fall(input int n, input string tag);
    int   falls = 0;
    logic prev  = bus.req;
    bit   ok    = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && bus.req === 1'b0) falls++;
      prev = bus.req;
      if (falls == n) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    logic [7:0] vals [$];
`ifdef ADC_READER_TIMEOUT_EN
    int req_hi;
`endif
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.rd_en = 1'b0;

    // Reset state.
    tick(3);
    check("rst_req",     32'(bus.req),     32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_count",   32'(bus.count),   32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_empty",   32'(bus.empty),   32'd1);
    check("rst_full",    32'(bus.full),    32'd0);
    rst = 1'b1;
    tick(2);

    // Terminated burst 10,20,30,255.
    vals = '{8'd10, 8'd20, 8'd30, 8'hFF};
    load_adc(vals);
    pulse_start();
    check("a_busy_after_start", 32'(bus.busy), 32'd1);
    wait_done("a_done_seen");
    check("a_count", 32'(bus.count), 32'd4);
    tick(1);
    check("a_done_one_cycle", 32'(bus.done), 32'd0);
    check("a_busy_low",       32'(bus.busy), 32'd0);
    tick(3);
    check("a_done_pulses", 32'(done_cnt), 32'd1);
    check("a_req_rises",   32'(rise_cnt), 32'd4);
    check("a_count_hold",  32'(bus.count), 32'd4);
    pop_check("a_pop0", 8'd10);
    pop_check("a_pop1", 8'd20);
    pop_check("a_pop2", 8'd30);
    pop_check("a_pop3", 8'hFF);
    check("a_empty", 32'(bus.empty), 32'd1);

    // DEPTH samples, no terminator: the buffer fills.
    vals = {};
    for (int i = 0; i < DEPTH; i++) vals.push_back(8'(i * 3 + 1));
    load_adc(vals);
    pulse_start();
    wait_done("b_done_seen");
    check("b_count", 32'(bus.count), 32'(DEPTH));
    check("b_full",  32'(bus.full),  32'd1);
    tick(3);
    check("b_req_rises", 32'(rise_cnt), 32'(DEPTH));
    check("b_count_sat", 32'(bus.count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("b_pop%0d", i), 8'(i * 3 + 1));
    check("b_empty",    32'(bus.empty), 32'd1);
    check("b_not_full", 32'(bus.full),  32'd0);
    // A pop on an empty buffer leaves rd_data and the pointers alone.
    pop_check("b_pop_empty_hold", 8'(DEPTH * 3 - 2));
    check("b_empty_after_pop", 32'(bus.empty), 32'd1);

    // Pop in the same cycle as the write of the second sample.
    vals = '{8'd40, 8'd50, 8'd60, 8'hFF};
    load_adc(vals);
    pulse_start();
    wait_req_fall(2, "c_second_capture_seen");
    pop_check("c_pop_during_capture", 8'd40);
    check("c_occupied", 32'(bus.empty), 32'd0);
    wait_done("c_done_seen");
    check("c_count", 32'(bus.count), 32'd4);
    tick(2);
    pop_check("c_pop1", 8'd50);
    pop_check("c_pop2", 8'd60);
    pop_check("c_pop3", 8'hFF);
    check("c_empty", 32'(bus.empty), 32'd1);

    // start pulses while busy are ignored.
    vals = '{8'd10, 8'd20, 8'd30, 8'hFF};
    load_adc(vals);
    pulse_start();
    tick(4);
    check("d_busy_before_restart", 32'(bus.busy), 32'd1);
    pulse_start();
    tick(10);
    pulse_start();
    wait_done("d_done_seen");
    check("d_count", 32'(bus.count), 32'd4);
    tick(3);
    check("d_done_pulses", 32'(done_cnt), 32'd1);
    check("d_req_rises",   32'(rise_cnt), 32'd4);
    pop_check("d_pop0", 8'd10);
    pop_check("d_pop1", 8'd20);
    pop_check("d_pop2", 8'd30);
    pop_check("d_pop3", 8'hFF);
    check("d_empty", 32'(bus.empty), 32'd1);

    // Reset while in WAIT aborts the burst and discards the buffer.
    vals = '{8'd5, 8'd6, 8'd7, 8'hFF};
    load_adc(vals);
    pulse_start();
    wait_req_fall(1, "e_first_capture_seen");
    tick(2);
    check("e_req_in_wait",   32'(bus.req),   32'd1);
    check("e_buffer_filled", 32'(bus.empty), 32'd0);
    rst      = 1'b0;
    adc_en   = 1'b0;
    done_cnt = 0;
    tick(1);
    check("e_rst_req",   32'(bus.req),   32'd0);
    check("e_rst_busy",  32'(bus.busy),  32'd0);
    check("e_rst_empty", 32'(bus.empty), 32'd1);
    check("e_rst_count", 32'(bus.count), 32'd0);
    rst = 1'b1;
    tick(10);
    check("e_no_done",    32'(done_cnt), 32'd0);
    check("e_still_idle", 32'(bus.busy), 32'd0);

`ifdef ADC_READER_TIMEOUT_EN
    // rdy never arrives. req is high for 1 ARM cycle plus TIMEOUT WAIT cycles.
    adc_en = 1'b0;
    check("t_err_clear_before", 32'(timeout_err), 32'd0);
    pulse_start();
    req_hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done === 1'b1) break;
      if (bus.req === 1'b1) req_hi++;
      @(negedge clk);
    end
    check("t_done",        32'(bus.done),    32'd1);
    check("t_req_cycles",  32'(req_hi),      32'(TIMEOUT + 1));
    check("t_timeout_err", 32'(timeout_err), 32'd1);
    check("t_count",       32'(bus.count),   32'd0);
    check("t_empty",       32'(bus.empty),   32'd1);
    tick(2);
    pulse_start();
    check("t_err_cleared_by_start", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_reader.md
ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 Parameter DEPTH, default 32: capture buffer entries, power of two.
REQ-002 Parameter TIMEOUT, default 255: max clk cycles spent waiting for rdy per sample.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port rst  in  1  synchronous, active-low reset.
REQ-005 Port start  in  1  one-cycle pulse that begins a capture burst.
REQ-006 Port req  out  1  sample request to the ADC.
REQ-007 Port rdy  in  1  ADC ready; asynchronous to clk.
REQ-008 Port dat  in  8  ADC sample; stable while rdy high.
REQ-009 Port busy  out  1  burst in progress.
REQ-010 Port done  out  1  one-cycle pulse at burst end.
REQ-011 Port count  out  6  samples captured in the current or last burst.
REQ-012 Port rd_en  in  1  pop one buffer entry.
REQ-013 Port rd_data  out  8  popped sample, valid the cycle after rd_en.
REQ-014 Port empty / full  out  1 each  buffer status.

Function
REQ-015 The rdy input shall pass through a two-flop synchroniser; only rdy_s is used internally.
REQ-016 FSM states shall be IDLE, ARM, WAIT, CAPTURE, DONE.
REQ-017 IDLE -> ARM on start; start clears the buffer and count. Start is ignored in all other states.
REQ-018 ARM: req driven 1, wait counter cleared, next state WAIT.
REQ-019 WAIT: req held 1; advance to CAPTURE when rdy_s=1 and at least 2 cycles have passed in WAIT.
REQ-020 CAPTURE: req driven 0 and dat written to the buffer; count increments by 1.
REQ-021 After CAPTURE, go to DONE if dat==8'hFF (terminator, stored), count reaches DEPTH, or the buffer is full. Otherwise return to ARM, so req stays low for exactly 1 cycle between requests.
REQ-022 DONE: done=1 for one cycle, then IDLE.
REQ-023 busy shall be 1 in every state except IDLE.
REQ-024 req shall be 1 only in ARM and WAIT. Each sample therefore produces one rising edge on req.
REQ-025 The buffer shall be a circular FIFO with wrap-around read/write pointers (log2(DEPTH) bits plus 1 wrap bit).
REQ-026 rd_en with empty=1 shall be ignored: pointers unchanged, rd_data holds its value.
REQ-027 A write to a full buffer shall never occur; REQ-021 prevents it.
REQ-028 A simultaneous pop and CAPTURE write shall both take effect in the same cycle; occupancy is unchanged.
REQ-029 rd_data shall be registered with 1-cycle latency after rd_en.
REQ-030 count shall saturate at DEPTH and hold its value after DONE until the next start.

Reset
REQ-031 When rst=0 at a clk edge: state=IDLE, req=0, busy=0, done=0, count=0, rd_data=0, pointers=0, empty=1, full=0, synchroniser flops=0.
REQ-032 Reset asserted mid-burst shall abort the burst with no done pulse and discard the buffer contents.

Configuration
REQ-033 Macro ADC_READER_TIMEOUT_EN.
- Defined: a wait counter runs in WAIT. When it reaches TIMEOUT without rdy_s, the FSM goes to DONE with no buffer write, and output timeout_err (1 bit) is set. timeout_err clears on start or reset.
- Undefined: WAIT waits indefinitely, no counter is built, and the timeout_err port is absent.

Verification
REQ-034 ADC model returns 10,20,30,255; pulse start -> 4 req rising edges; buffer holds 10,20,30,255; count=4; one done pulse; busy low after DONE.
REQ-035 Model returns 32 non-255 values, DEPTH=32 -> count=32, full=1, done pulse; then 32 rd_en pops return values in order and empty=1.
REQ-036 Pop during capture: rd_en issued in the same cycle as a CAPTURE write -> occupancy unchanged, data order preserved.
REQ-037 rst=0 while in WAIT -> next cycle req=0, busy=0, empty=1, count=0, and no done pulse.
REQ-038 With ADC_READER_TIMEOUT_EN defined, TIMEOUT=8, rdy held 0 -> req high for 8 cycles in WAIT, then done=1, timeout_err=1, count=0.
REQ-039 start pulsed while busy=1 -> ignored; the burst result is identical to an undisturbed run.
